// File: rtl/alarm_responder_pkg.sv
// ---------------------------------------------------------------------------
// alarm_responder_pkg: state encodings, BCD limits and BCD conversion helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alarm_responder_pkg;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_ring   = 2'd1;
  localparam logic [1:0] c_st_snooze = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = c_st_idle,
    ST_RING   = c_st_ring,
    ST_SNOOZE = c_st_snooze,
    ST_DONE   = c_st_done
  } state_t;

  localparam logic [7:0] c_bcd_min_max = 8'h59;
  localparam logic [7:0] c_bcd_hr_max  = 8'h23;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    tens = 4'(v / 7'd10);
    return {tens, 4'(v - 7'(tens) * 7'd10)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_responder_if.sv
// ---------------------------------------------------------------------------
// alarm_responder_if: time, key, tone and speaker signals of the alarm responder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alarm_responder_if;
  logic       tick_1hz;
  logic       alarm_en;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic [7:0] set_hr;
  logic [7:0] set_min;
  logic       stop_key;
  logic       snooze_key;
  logic       beep_2hz;
  logic       tone_500hz;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_cnt;
  logic [7:0] snz_hr;
  logic [7:0] snz_min;

  modport slave (
    input  tick_1hz, alarm_en, hour, minute, second, set_hr, set_min,
           stop_key, snooze_key, beep_2hz, tone_500hz,
    output buzzer, ringing, snoozing, snooze_cnt, snz_hr, snz_min
  );

  modport master (
    output tick_1hz, alarm_en, hour, minute, second, set_hr, set_min,
           stop_key, snooze_key, beep_2hz, tone_500hz,
    input  buzzer, ringing, snoozing, snooze_cnt, snz_hr, snz_min
  );
endinterface

`default_nettype wire

// File: rtl/alarm_responder_bcd_time_add.sv
// ---------------------------------------------------------------------------
// bcd_time_add: adds 0..59 minutes to a BCD HH:MM, wrapping 59->00 and 23->00.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_time_add
  import alarm_responder_pkg::*;
(
  input  logic [7:0] i_hr,
  input  logic [7:0] i_min,
  input  logic [5:0] i_add,
  output logic [7:0] o_hr,
  output logic [7:0] o_min
);

  logic [6:0] w_min_sum;
  logic [6:0] w_hr_sum;
  logic       w_carry;

  always_comb begin
    w_min_sum = bcd2bin(i_min) + 7'(i_add);
    w_carry   = 1'b0;
    if (w_min_sum > bcd2bin(c_bcd_min_max)) begin
      w_min_sum = w_min_sum - 7'd60;
      w_carry   = 1'b1;
    end
    w_hr_sum = bcd2bin(i_hr) + 7'(w_carry);
    if (w_hr_sum > bcd2bin(c_bcd_hr_max)) begin
      w_hr_sum = 7'd0;
    end
    o_min = bin2bcd(w_min_sum);
    o_hr  = bin2bcd(w_hr_sum);
  end

endmodule

`default_nettype wire

// File: rtl/alarm_responder.sv
// ---------------------------------------------------------------------------
// alarm_responder: alarm hit detection, ring/snooze/stop FSM and buzzer drive.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_responder
  import alarm_responder_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  alarm_responder_if.slave  bus
);

  localparam logic [7:0] c_ring_sec   = 8'(RING_SEC);
  localparam logic [2:0] c_max_snooze = 3'(MAX_SNOOZE);
  localparam logic [5:0] c_snooze_min = 6'(SNOOZE_MIN);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] snz_hr_q, snz_hr_d;
  logic [7:0] snz_min_q, snz_min_d;
  logic       ringing_q, ringing_d;
  logic       snoozing_q, snoozing_d;
  logic       armed_q, armed_d;
  logic       stop_lvl_q, stop_lvl_d, stop_prev_q, stop_prev_d;
  logic       snz_lvl_q, snz_lvl_d, snz_prev_q, snz_prev_d;

  logic       w_stop_pulse, w_snz_pulse, w_hit_set, w_hit_snz, w_can_snooze;
  logic [7:0] w_add_hr, w_add_min;

  bcd_time_add u_add (
    .i_hr  (bus.hour),
    .i_min (bus.minute),
    .i_add (c_snooze_min),
    .o_hr  (w_add_hr),
    .o_min (w_add_min)
  );

  // First cycle out of reset loads both key stages so a held key cannot pulse.
  always_comb begin
    armed_d     = 1'b1;
    stop_lvl_d  = bus.stop_key;
    snz_lvl_d   = bus.snooze_key;
    stop_prev_d = armed_q ? stop_lvl_q : bus.stop_key;
    snz_prev_d  = armed_q ? snz_lvl_q  : bus.snooze_key;
  end

  assign w_stop_pulse = stop_lvl_q & ~stop_prev_q;
  assign w_snz_pulse  = snz_lvl_q & ~snz_prev_q;
  assign w_can_snooze = (cnt_q < c_max_snooze);
  assign w_hit_set    = bus.tick_1hz && (bus.hour == bus.set_hr) &&
                        (bus.minute == bus.set_min) && (bus.second == 8'h00);
  assign w_hit_snz    = bus.tick_1hz && (bus.hour == snz_hr_q) &&
                        (bus.minute == snz_min_q) && (bus.second == 8'h00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    snz_hr_d  = snz_hr_q;
    snz_min_d = snz_min_q;
    if (!bus.alarm_en) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (w_hit_set) begin
            state_d = ST_RING;
            cnt_d   = 3'd0;
            tmr_d   = c_ring_sec;
          end
        end
        ST_RING: begin
          if (w_stop_pulse) begin
            state_d = ST_DONE;
          end else if (w_snz_pulse && w_can_snooze) begin
            state_d   = ST_SNOOZE;
            cnt_d     = cnt_q + 3'd1;
            snz_hr_d  = w_add_hr;
            snz_min_d = w_add_min;
          end else if (bus.tick_1hz) begin
            tmr_d = tmr_q - 8'd1;
            if (tmr_q == 8'd1) begin
              if (w_can_snooze) begin
                state_d   = ST_SNOOZE;
                cnt_d     = cnt_q + 3'd1;
                snz_hr_d  = w_add_hr;
                snz_min_d = w_add_min;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_SNOOZE: begin
          if (w_stop_pulse) begin
            state_d = ST_DONE;
          end else if (w_hit_snz) begin
            state_d = ST_RING;
            tmr_d   = c_ring_sec;
          end
        end
        ST_DONE: begin
          // Leaving only on a different minute prevents a second hit on the same alarm minute.
          if (bus.tick_1hz && (bus.minute != bus.set_min)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      tmr_q       <= 8'd0;
      snz_hr_q    <= 8'h00;
      snz_min_q   <= 8'h00;
      ringing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
      armed_q     <= 1'b0;
      stop_lvl_q  <= 1'b0;
      stop_prev_q <= 1'b0;
      snz_lvl_q   <= 1'b0;
      snz_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      snz_hr_q    <= snz_hr_d;
      snz_min_q   <= snz_min_d;
      ringing_q   <= ringing_d;
      snoozing_q  <= snoozing_d;
      armed_q     <= armed_d;
      stop_lvl_q  <= stop_lvl_d;
      stop_prev_q <= stop_prev_d;
      snz_lvl_q   <= snz_lvl_d;
      snz_prev_q  <= snz_prev_d;
    end
  end

  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = cnt_q;
  assign bus.snz_hr     = snz_hr_q;
  assign bus.snz_min    = snz_min_q;
  assign bus.buzzer     = ringing_q & bus.alarm_en &
                          (bus.second[0] ? bus.beep_2hz : bus.tone_500hz);

endmodule

`default_nettype wire

// File: tb/tb_alarm_responder.sv
// ---------------------------------------------------------------------------
// tb_alarm_responder: vector table and scoreboard checks for alarm_responder.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alarm_responder;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alarm_responder_if bus ();

  alarm_responder #(
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (3),
    .RING_SEC   (60)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ctl = {tick, en, stop, snooze, 2hz, 500hz}; st = {ringing, snoozing, buzzer}
  typedef struct {
    string      nm;
    logic [5:0] ctl;
    logic [7:0] h, m, s;
    logic [2:0] st;
    logic [2:0] cnt;
    logic [7:0] shr, smin;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic [5:0] ctl,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [2:0] st, input logic [2:0] cnt,
                              input logic [7:0] shr, input logic [7:0] smin);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.h = h; v.m = m; v.s = s;
    v.st = st; v.cnt = cnt; v.shr = shr; v.smin = smin;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check_out();
    vec_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = exp_q.pop_front();
    if (bus.ringing !== e.st[2] || bus.snoozing !== e.st[1] || bus.buzzer !== e.st[0] ||
        bus.snooze_cnt !== e.cnt || bus.snz_hr !== e.shr || bus.snz_min !== e.smin) begin
      n_bad++;
      $display("FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d at=%h:%h, want ring=%b snz=%b buz=%b cnt=%0d at=%h:%h",
               e.nm, bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_cnt, bus.snz_hr, bus.snz_min,
               e.st[2], e.st[1], e.st[0], e.cnt, e.shr, e.smin);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.tick_1hz   = v.ctl[5];
    bus.alarm_en   = v.ctl[4];
    bus.stop_key   = v.ctl[3];
    bus.snooze_key = v.ctl[2];
    bus.beep_2hz   = v.ctl[1];
    bus.tone_500hz = v.ctl[0];
    bus.hour       = v.h;
    bus.minute     = v.m;
    bus.second     = v.s;
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input logic [7:0] shr, input logic [7:0] smin);
    rst_n       = 1'b0;
    bus.set_hr  = shr;
    bus.set_min = smin;
    drive(mk("idle", 6'b010000, 8'h00, 8'h00, 8'h01, 3'b000, 3'd0, 8'h00, 8'h00));
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk("reset_state", 6'b0, 8'h00, 8'h00, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snooze_cycle(input logic [2:0] k, input logic [7:0] m_now,
                              input logic [7:0] m_prev, input logic [7:0] m_new);
    apply(mk("t4_press_a", 6'b010100, 8'h07, m_now, 8'h05, 3'b100, k - 3'd1, 8'h07, m_prev));
    apply(mk("t4_press_b", 6'b010100, 8'h07, m_now, 8'h05, 3'b010, k, 8'h07, m_new));
    apply(mk("t4_release", 6'b010000, 8'h07, m_now, 8'h06, 3'b010, k, 8'h07, m_new));
    apply(mk("t4_rering",  6'b110000, 8'h07, m_new, 8'h00, 3'b100, k, 8'h07, m_new));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk("pre_alarm",  6'b110010, 8'h06, 8'h29, 8'h59, 3'b000, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("hit",        6'b110010, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("tone_even",  6'b010001, 8'h06, 8'h30, 8'h00, 3'b101, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("beep_odd_0", 6'b110001, 8'h06, 8'h30, 8'h01, 3'b100, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("beep_odd_1", 6'b010010, 8'h06, 8'h30, 8'h01, 3'b101, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("snz_key_a",  6'b110101, 8'h06, 8'h30, 8'h10, 3'b101, 3'd0, 8'h00, 8'h00));
    tbl.push_back(mk("snz_key_b",  6'b010101, 8'h06, 8'h30, 8'h10, 3'b010, 3'd1, 8'h06, 8'h35));
    tbl.push_back(mk("snz_wait",   6'b110011, 8'h06, 8'h34, 8'h59, 3'b010, 3'd1, 8'h06, 8'h35));
    tbl.push_back(mk("snz_rering", 6'b110011, 8'h06, 8'h35, 8'h00, 3'b101, 3'd1, 8'h06, 8'h35));
    tbl.push_back(mk("both_keys_a",6'b011111, 8'h06, 8'h35, 8'h02, 3'b101, 3'd1, 8'h06, 8'h35));
    tbl.push_back(mk("both_keys_b",6'b011111, 8'h06, 8'h35, 8'h02, 3'b000, 3'd1, 8'h06, 8'h35));
    tbl.push_back(mk("done_idle",  6'b110011, 8'h06, 8'h35, 8'h03, 3'b000, 3'd1, 8'h06, 8'h35));

    // Reset with the snooze key held and an alarm hit on the first live edge.
    rst_n       = 1'b0;
    bus.set_hr  = 8'h06;
    bus.set_min = 8'h30;
    drive(mk("held", 6'b110100, 8'h06, 8'h30, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk("reset_state", 6'b0, 8'h00, 8'h00, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("rst_hit",    6'b110100, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("held_key_a", 6'b010100, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("held_key_b", 6'b010100, 8'h06, 8'h30, 8'h01, 3'b100, 3'd0, 8'h00, 8'h00));

    do_reset(8'h06, 8'h30);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Stop+snooze together, then no re-ring within the alarm minute.
    do_reset(8'h06, 8'h30);
    apply(mk("t5_hit",        6'b110000, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_both_a",     6'b011100, 8'h06, 8'h30, 8'h05, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_both_b",     6'b011100, 8'h06, 8'h30, 8'h05, 3'b000, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_done_hold",  6'b110000, 8'h06, 8'h30, 8'h06, 3'b000, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_no_rering",  6'b110000, 8'h06, 8'h30, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_leave_done", 6'b110000, 8'h06, 8'h31, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    apply(mk("t5_rearm",      6'b110000, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));

    // Midnight wrap of the snooze time, then asynchronous reset while ringing.
    do_reset(8'h23, 8'h58);
    apply(mk("t3_hit",    6'b110000, 8'h23, 8'h58, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t3_snz_a",  6'b110100, 8'h23, 8'h58, 8'h20, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t3_snz_b",  6'b010100, 8'h23, 8'h58, 8'h20, 3'b010, 3'd1, 8'h00, 8'h03));
    apply(mk("t3_rering", 6'b110001, 8'h00, 8'h03, 8'h00, 3'b101, 3'd1, 8'h00, 8'h03));
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk("t6_async_rst", 6'b0, 8'h00, 8'h00, 8'h00, 3'b000, 3'd0, 8'h00, 8'h00));
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Auto-snooze on timeout, snooze limit, then timeout into DONE.
    do_reset(8'h07, 8'h00);
    apply(mk("t4_hit", 6'b110000, 8'h07, 8'h00, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    for (int i = 1; i <= 60; i++) begin
      if (i < 60)
        apply(mk("t4_ring_tmr", 6'b110000, 8'h07, to_bcd(i / 60), to_bcd(i % 60),
                 3'b100, 3'd0, 8'h00, 8'h00));
      else
        apply(mk("t4_auto_snz", 6'b110000, 8'h07, to_bcd(i / 60), to_bcd(i % 60),
                 3'b010, 3'd1, 8'h07, 8'h06));
    end
    apply(mk("t4_ring2", 6'b110000, 8'h07, 8'h06, 8'h00, 3'b100, 3'd1, 8'h07, 8'h06));
    snooze_cycle(3'd2, 8'h06, 8'h06, 8'h11);
    snooze_cycle(3'd3, 8'h11, 8'h11, 8'h16);
    apply(mk("t4_4th_a",    6'b010100, 8'h07, 8'h16, 8'h05, 3'b100, 3'd3, 8'h07, 8'h16));
    apply(mk("t4_4th_b",    6'b010100, 8'h07, 8'h16, 8'h05, 3'b100, 3'd3, 8'h07, 8'h16));
    apply(mk("t4_4th_rel",  6'b010000, 8'h07, 8'h16, 8'h06, 3'b100, 3'd3, 8'h07, 8'h16));
    for (int i = 1; i <= 60; i++) begin
      if (i < 60)
        apply(mk("t4_final_tmr", 6'b110011, 8'h07, to_bcd(16 + i / 60), to_bcd(i % 60),
                 3'b101, 3'd3, 8'h07, 8'h16));
      else
        apply(mk("t4_timeout_done", 6'b110011, 8'h07, to_bcd(16 + i / 60), to_bcd(i % 60),
                 3'b000, 3'd3, 8'h07, 8'h16));
    end

    // AlarmEn low during SNOOZE, and overriding a hit.
    do_reset(8'h06, 8'h30);
    apply(mk("t6_hit",        6'b110000, 8'h06, 8'h30, 8'h00, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t6_snz_a",      6'b010100, 8'h06, 8'h30, 8'h05, 3'b100, 3'd0, 8'h00, 8'h00));
    apply(mk("t6_snz_b",      6'b010100, 8'h06, 8'h30, 8'h05, 3'b010, 3'd1, 8'h06, 8'h35));
    apply(mk("t6_en_off",     6'b000000, 8'h06, 8'h30, 8'h06, 3'b000, 3'd0, 8'h06, 8'h35));
    apply(mk("t6_no_snz_hit", 6'b110000, 8'h06, 8'h35, 8'h00, 3'b000, 3'd0, 8'h06, 8'h35));
    apply(mk("t6_en_off_hit", 6'b100000, 8'h06, 8'h30, 8'h00, 3'b000, 3'd0, 8'h06, 8'h35));
    apply(mk("t6_en_back",    6'b010000, 8'h06, 8'h30, 8'h00, 3'b000, 3'd0, 8'h06, 8'h35));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
